sp16_unit: RTL and testbench

16-bit stack-pointer unit that owns the SP register and drives the data-memory address for push/pop operations. It is the sequential counterpart of `inc16`: it holds the value, uses `inc16` for its arithmetic, and writes the result back. Pushes use `inc16` with direction = decrement, and pops use direction = increment. The unit sits between the instruction decoder (request side) and the data-memory port (access side).

---
 rtl/sp16_unit.sv | 166 ++++++++++++++++
 tb/tb_sp16_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp16_unit.sv
// Stack-pointer unit: owns SP and sequences push/pop accesses to data memory.
// Optional SP16_BOUNDS_CHECK_EN enables P_LIMIT/P_TOP fault detection and sticky flags.

module inc16 (
  input  logic [15:0] i_a,
  input  logic        i_dec,
  output logic [15:0] o_y
);
  assign o_y = i_dec ? (i_a - 16'd1) : (i_a + 16'd1);
endmodule

module sp16_unit #(
  parameter logic [15:0] P_TOP   = 16'hFFFF,
  parameter logic [15:0] P_LIMIT = 16'hFF00
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  input  logic        i_req_push,
  output logic        o_req_ready,
  input  logic        i_load,
  input  logic [15:0] i_load_val,
  input  logic        i_clr_flags,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  input  logic        i_mem_ack,
  output logic [15:0] o_sp,
  output logic        o_done,
  output logic        o_err,
  output logic        o_ovf,
  output logic        o_unf
);

  localparam int unsigned W = 16;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t         r_state;
  logic [W-1:0]   r_sp;
  logic [W-1:0]   r_addr;
  logic           r_push;
  logic           r_mem_en;
  logic           r_mem_we;
  logic           r_done;
  logic           r_err;

  logic           w_idle;
  logic           w_load;
  logic           w_accept;
  logic           w_dec;
  logic           w_ovf_hit;
  logic           w_unf_hit;
  logic           w_fault;
  logic [W-1:0]   w_step;

  assign w_idle      = (r_state == S_IDLE);
  assign w_load      = w_idle & i_load;
  assign o_req_ready = w_idle & ~i_load;
  assign w_accept    = i_req_valid & o_req_ready;

  // In IDLE the step precomputes the push address; in ACCESS it is the SP write-back value.
  assign w_dec = w_idle ? i_req_push : r_push;

  inc16 u_inc16 (
    .i_a   (r_sp),
    .i_dec (w_dec),
    .o_y   (w_step)
  );

`ifdef SP16_BOUNDS_CHECK_EN
  logic r_ovf;
  logic r_unf;

  assign w_ovf_hit = w_accept &  i_req_push & (r_sp == P_LIMIT);
  assign w_unf_hit = w_accept & ~i_req_push & (r_sp == P_TOP);

  // Sticky fault flags; a set in the same cycle as a clear wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (w_load) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (i_clr_flags) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end
      if (w_ovf_hit) r_ovf <= 1'b1;
      if (w_unf_hit) r_unf <= 1'b1;
    end
  end

  assign o_ovf = r_ovf;
  assign o_unf = r_unf;
`else
  logic w_unused;

  assign w_ovf_hit = 1'b0;
  assign w_unf_hit = 1'b0;
  assign w_unused  = ^{i_clr_flags, P_LIMIT};
  assign o_ovf     = 1'b0;
  assign o_unf     = 1'b0;
`endif

  assign w_fault = w_ovf_hit | w_unf_hit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_sp     <= P_TOP;
      r_addr   <= 16'h0000;
      r_push   <= 1'b0;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_sp <= i_load_val;
          end else if (w_accept) begin
            if (w_fault) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state  <= S_ACCESS;
              r_push   <= i_req_push;
              r_mem_en <= 1'b1;
              r_mem_we <= i_req_push;
              r_addr   <= i_req_push ? w_step : r_sp;
            end
          end
        end
        S_ACCESS: begin
          if (i_mem_ack) begin
            r_sp     <= w_step;
            r_mem_en <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_mem_en   = r_mem_en;
  assign o_mem_we   = r_mem_we;
  assign o_mem_addr = r_addr;
  assign o_sp       = r_sp;
  assign o_done     = r_done;
  assign o_err      = r_err;

endmodule

// File: tb/tb_sp16_unit.sv
// Directed bench for sp16_unit: per-cycle vector table plus hand sequences for faults and reset.
`timescale 1ns/1ps

module tb_sp16_unit;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        i_req_push;
  logic        o_req_ready;
  logic        i_load;
  logic [15:0] i_load_val;
  logic        i_clr_flags;
  logic        o_mem_en;
  logic        o_mem_we;
  logic [15:0] o_mem_addr;
  logic        i_mem_ack;
  logic [15:0] o_sp;
  logic        o_done;
  logic        o_err;
  logic        o_ovf;
  logic        o_unf;

  int checks   = 0;
  int failures = 0;

  sp16_unit dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .i_req_push  (i_req_push),
    .o_req_ready (o_req_ready),
    .i_load      (i_load),
    .i_load_val  (i_load_val),
    .i_clr_flags (i_clr_flags),
    .o_mem_en    (o_mem_en),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .i_mem_ack   (i_mem_ack),
    .o_sp        (o_sp),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_ovf       (o_ovf),
    .o_unf       (o_unf)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    logic        v;
    logic        p;
    logic        ld;
    logic [15:0] lval;
    logic        clr;
    logic        ack;
    logic        rdy;
    logic        en;
    logic        we;
    logic [15:0] addr;
    logic [15:0] sp;
    logic        done;
    logic        err;
  } vec_t;

  localparam int NVEC = 13;
  vec_t tbl [NVEC];

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h exp=%h t=%0t", nm, idx, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply(input vec_t t, input int idx);
    i_req_valid = t.v;
    i_req_push  = t.p;
    i_load      = t.ld;
    i_load_val  = t.lval;
    i_clr_flags = t.clr;
    i_mem_ack   = t.ack;
    #1;
    chk("ready", idx, 16'(o_req_ready), 16'(t.rdy));
    tick();
    chk("mem_en", idx, 16'(o_mem_en), 16'(t.en));
    chk("mem_we", idx, 16'(o_mem_we), 16'(t.we));
    chk("mem_addr", idx, o_mem_addr, t.addr);
    chk("sp", idx, o_sp, t.sp);
    chk("done", idx, 16'(o_done), 16'(t.done));
    chk("err", idx, 16'(o_err), 16'(t.err));
    chk("ovf", idx, 16'(o_ovf), 16'h0);
    chk("unf", idx, 16'(o_unf), 16'h0);
  endtask

  initial begin
    //           v     p     ld    lval      clr   ack   rdy   en    we    addr      sp        done  err
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFE, 16'hFFFF, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFE, 16'hFFFE, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE, 16'h1234, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h1235, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h1235, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h1235, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};

    i_rst_n     = 1'b0;
    i_req_valid = 1'b0;
    i_req_push  = 1'b0;
    i_load      = 1'b0;
    i_load_val  = 16'h0000;
    i_clr_flags = 1'b0;
    i_mem_ack   = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    #1;

    // Reset state
    chk("rst_ready", -1, 16'(o_req_ready), 16'h1);
    chk("rst_mem_en", -1, 16'(o_mem_en), 16'h0);
    chk("rst_mem_we", -1, 16'(o_mem_we), 16'h0);
    chk("rst_addr", -1, o_mem_addr, 16'h0000);
    chk("rst_sp", -1, o_sp, 16'hFFFF);
    chk("rst_done", -1, 16'(o_done), 16'h0);
    chk("rst_err", -1, 16'(o_err), 16'h0);
    chk("rst_ovf", -1, 16'(o_ovf), 16'h0);
    chk("rst_unf", -1, 16'(o_unf), 16'h0);

    for (int i = 0; i < NVEC; i++) apply(tbl[i], i);
    i_mem_ack = 1'b0;

    // Push near the limit with a 3-cycle memory wait, then push at the limit
    i_load = 1'b1; i_load_val = 16'hFF01;
    tick();
    i_load = 1'b0;
    chk("A_load_sp", -1, o_sp, 16'hFF01);
    i_req_valid = 1'b1; i_req_push = 1'b1;
    #1;
    chk("A_ready1", -1, 16'(o_req_ready), 16'h1);
    tick();
    i_req_valid = 1'b0;
    chk("A_en", -1, 16'(o_mem_en), 16'h1);
    chk("A_we", -1, 16'(o_mem_we), 16'h1);
    chk("A_addr", -1, o_mem_addr, 16'hFF00);
    for (int w = 0; w < 3; w++) begin
      tick();
      chk("A_wait_en", w, 16'(o_mem_en), 16'h1);
      chk("A_wait_addr", w, o_mem_addr, 16'hFF00);
      chk("A_wait_done", w, 16'(o_done), 16'h0);
    end
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0;
    chk("A_done", -1, 16'(o_done), 16'h1);
    chk("A_sp", -1, o_sp, 16'hFF00);
    chk("A_err", -1, 16'(o_err), 16'h0);
    tick();
    i_req_valid = 1'b1; i_req_push = 1'b1;
    #1;
    chk("A_ready2", -1, 16'(o_req_ready), 16'h1);
    tick();
    i_req_valid = 1'b0;
`ifdef SP16_BOUNDS_CHECK_EN
    chk("A2_done", -1, 16'(o_done), 16'h1);
    chk("A2_err", -1, 16'(o_err), 16'h1);
    chk("A2_ovf", -1, 16'(o_ovf), 16'h1);
    chk("A2_en", -1, 16'(o_mem_en), 16'h0);
    chk("A2_sp", -1, o_sp, 16'hFF00);
    tick();
    chk("A2_done_end", -1, 16'(o_done), 16'h0);
    chk("A2_err_end", -1, 16'(o_err), 16'h0);
    chk("A2_ovf_sticky", -1, 16'(o_ovf), 16'h1);
    chk("A2_en_end", -1, 16'(o_mem_en), 16'h0);
`else
    chk("A2_en", -1, 16'(o_mem_en), 16'h1);
    chk("A2_addr", -1, o_mem_addr, 16'hFEFF);
    chk("A2_err", -1, 16'(o_err), 16'h0);
    chk("A2_ovf", -1, 16'(o_ovf), 16'h0);
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0;
    chk("A2_done", -1, 16'(o_done), 16'h1);
    chk("A2_sp", -1, o_sp, 16'hFEFF);
    chk("A2_err_done", -1, 16'(o_err), 16'h0);
    tick();
`endif

    // Pop at the top of stack, with a same-cycle flag clear
    i_load = 1'b1; i_load_val = 16'hFFFF;
    tick();
    i_load = 1'b0;
    chk("B_load_sp", -1, o_sp, 16'hFFFF);
    chk("B_load_clears_ovf", -1, 16'(o_ovf), 16'h0);
    i_req_valid = 1'b1; i_req_push = 1'b0; i_clr_flags = 1'b1;
    tick();
    i_req_valid = 1'b0; i_clr_flags = 1'b0;
`ifdef SP16_BOUNDS_CHECK_EN
    chk("B_done", -1, 16'(o_done), 16'h1);
    chk("B_err", -1, 16'(o_err), 16'h1);
    chk("B_unf_set_wins", -1, 16'(o_unf), 16'h1);
    chk("B_en", -1, 16'(o_mem_en), 16'h0);
    chk("B_sp", -1, o_sp, 16'hFFFF);
    tick();
    chk("B_done_end", -1, 16'(o_done), 16'h0);
    chk("B_unf_sticky", -1, 16'(o_unf), 16'h1);
`else
    chk("B_en", -1, 16'(o_mem_en), 16'h1);
    chk("B_we", -1, 16'(o_mem_we), 16'h0);
    chk("B_addr", -1, o_mem_addr, 16'hFFFF);
    chk("B_unf", -1, 16'(o_unf), 16'h0);
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0;
    chk("B_done", -1, 16'(o_done), 16'h1);
    chk("B_sp_wrap", -1, o_sp, 16'h0000);
    chk("B_err", -1, 16'(o_err), 16'h0);
    tick();
`endif
    i_clr_flags = 1'b1;
    tick();
    i_clr_flags = 1'b0;
    chk("B_unf_clr", -1, 16'(o_unf), 16'h0);
    chk("B_ovf_clr", -1, 16'(o_ovf), 16'h0);

    // Asynchronous reset in the middle of an access, then a late ack
    i_req_valid = 1'b1; i_req_push = 1'b1;
    tick();
    i_req_valid = 1'b0;
    chk("C_en", -1, 16'(o_mem_en), 16'h1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("C_en_async", -1, 16'(o_mem_en), 16'h0);
    chk("C_sp_async", -1, o_sp, 16'hFFFF);
    chk("C_done_async", -1, 16'(o_done), 16'h0);
    tick();
    i_rst_n = 1'b1;
    i_mem_ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("C_late_done", k, 16'(o_done), 16'h0);
      chk("C_late_en", k, 16'(o_mem_en), 16'h0);
      chk("C_late_sp", k, o_sp, 16'hFFFF);
    end
    i_mem_ack = 1'b0;
    #1;
    chk("C_ready", -1, 16'(o_req_ready), 16'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
